// File: rtl/score_disp_pkg.sv
// Shared types, constants and sizing helpers for the score display controller.
package score_disp_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CONVERT = 2'd1,
      DECODE  = 2'd2,
      COMMIT  = 2'd3
   } state_t;

   localparam logic [6:0] SEG_BLANK = 7'h7F;

   function automatic int unsigned pow10(input int unsigned n);
      int unsigned r;
      r = 1;
      for (int unsigned i = 0; i < n; i++) r = r * 10;
      return r;
   endfunction

   function automatic int unsigned cnt_w(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/seven_segment_display.sv
// Hex digit to active-low 7-segment pattern, segments ordered {g,f,e,d,c,b,a}.
module seven_segment_display (
   input  logic [3:0] digit,
   output logic [6:0] seg
);

   always_comb begin
      case (digit)
         4'h0:    seg = 7'h40;
         4'h1:    seg = 7'h79;
         4'h2:    seg = 7'h24;
         4'h3:    seg = 7'h30;
         4'h4:    seg = 7'h19;
         4'h5:    seg = 7'h12;
         4'h6:    seg = 7'h02;
         4'h7:    seg = 7'h78;
         4'h8:    seg = 7'h00;
         4'h9:    seg = 7'h10;
         4'hA:    seg = 7'h08;
         4'hB:    seg = 7'h03;
         4'hC:    seg = 7'h46;
         4'hD:    seg = 7'h21;
         4'hE:    seg = 7'h06;
         default: seg = 7'h0E;
      endcase
   end

endmodule

// File: rtl/score_display_ctrl.sv
// Binary score to multi-digit 7-segment image: serial double-dabble, one shared
// decoder time-shared across digits, atomic commit of all digits to hex_out.
module score_display_ctrl
   import score_disp_pkg::*;
#(
   parameter int unsigned BIN_W    = 14,
   parameter int unsigned DIGITS   = 4,
   parameter int unsigned BLANK_LZ = 1
) (
   input  logic                  clock,
   input  logic                  resetn,
   input  logic [BIN_W-1:0]      in_value,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic                  busy,
   output logic                  done,
   output logic [7*DIGITS-1:0]   hex_out
);

   localparam int unsigned   BW   = cnt_w(BIN_W);
   localparam int unsigned   IW   = cnt_w(DIGITS);
   localparam int unsigned   NB   = 4 * DIGITS;
   localparam logic [BIN_W-1:0] MAXV = BIN_W'(pow10(DIGITS) - 1);

   state_t            state, state_nx;
   logic [BIN_W-1:0]  bin_q;
   logic [NB-1:0]     bcd_q, bcd_adj;
   logic [BW-1:0]     bit_cnt;
   logic [IW-1:0]     idx;
   logic [6:0]        shadow [DIGITS];
   logic [3:0]        nib [DIGITS];
   logic [DIGITS-1:0] upper_zero;
   logic [6:0]        seg;
   logic              blank;
   logic              run_zero;

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) state <= IDLE;
      else         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (in_valid)              state_nx = CONVERT;
         CONVERT: if (bit_cnt == '0)         state_nx = DECODE;
         DECODE:  if (idx == IW'(DIGITS-1))  state_nx = COMMIT;
         COMMIT:                             state_nx = IDLE;
         default:                            state_nx = IDLE;
      endcase
   end

   always_comb begin
      in_ready = (state == IDLE);
      busy     = (state != IDLE);
   end

   // add-3 correction applied before each left shift
   always_comb begin
      bcd_adj = bcd_q;
      for (int unsigned i = 0; i < DIGITS; i++)
         if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
   end

   // upper_zero[i]: nibble i and every nibble above it are zero
   always_comb begin
      run_zero   = 1'b1;
      upper_zero = '0;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         nib[i] = bcd_q[4*i +: 4];
      end
      for (int unsigned i = 0; i < DIGITS; i++) begin
         run_zero = run_zero & (nib[DIGITS-1-i] == 4'd0);
         upper_zero[DIGITS-1-i] = run_zero;
      end
      blank = (BLANK_LZ != 0) && (idx != '0) && upper_zero[idx];
   end

   seven_segment_display u_dec (
      .digit (nib[idx]),
      .seg   (seg)
   );

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         bin_q   <= '0;
         bcd_q   <= '0;
         bit_cnt <= '0;
         idx     <= '0;
         done    <= 1'b0;
         hex_out <= '1;
         for (int unsigned i = 0; i < DIGITS; i++) shadow[i] <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: if (in_valid) begin
               bin_q   <= (32'(in_value) >= pow10(DIGITS)) ? MAXV : in_value;
               bcd_q   <= '0;
               bit_cnt <= BW'(BIN_W - 1);
               idx     <= '0;
            end
            CONVERT: begin
               {bcd_q, bin_q} <= {bcd_adj, bin_q} << 1;
               bit_cnt        <= bit_cnt - 1'b1;
            end
            DECODE: begin
               shadow[idx] <= blank ? SEG_BLANK : seg;
               idx         <= idx + 1'b1;
            end
            COMMIT: begin
               for (int unsigned i = 0; i < DIGITS; i++) hex_out[7*i +: 7] <= shadow[i];
               done <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_score_display_ctrl.sv
// Directed bench for score_display_ctrl: table of values with hand-decoded images
// plus sequences for back-to-back handshake and reset mid-conversion.
module tb_score_display_ctrl;

   logic        clk = 1'b0;
   logic        resetn;
   logic [13:0] in_value;
   logic        in_valid;
   logic        in_ready;
   logic        busy;
   logic        done;
   logic [27:0] hex_out;

   int unsigned n_pass  = 0;
   int unsigned n_total = 0;

   always #5 clk = ~clk;

   score_display_ctrl #(.BIN_W(14), .DIGITS(4), .BLANK_LZ(1)) dut (
      .clock    (clk),
      .resetn   (resetn),
      .in_value (in_value),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .busy     (busy),
      .done     (done),
      .hex_out  (hex_out)
   );

   typedef struct {
      logic [13:0] value;
      logic [27:0] hex;
   } vec_t;

   vec_t vecs [12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   // accept v, then count edges until done; checks latency, busy and hold
   task automatic run_value(input string name, input logic [13:0] v, input logic [27:0] exp);
      int unsigned lat;
      logic        busy_ok;
      logic [27:0] img;
      @(negedge clk);
      in_value = v;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      busy_ok  = busy && !in_ready;
      lat      = 0;
      while (lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
         if (done) break;
         if (!busy || in_ready) busy_ok = 1'b0;
      end
      img = hex_out;
      chk({name, " latency"}, lat, 19);
      chk({name, " busy"}, {31'd0, busy_ok}, 1);
      chk({name, " idle_at_done"}, {30'd0, in_ready, busy}, 2'b10);
      chk({name, " hex"}, {4'd0, img}, {4'd0, exp});
      @(posedge clk);
      #1;
      chk({name, " done_pulse"}, {31'd0, done}, 0);
      chk({name, " hold"}, {4'd0, hex_out}, {4'd0, exp});
   endtask

   initial begin
      int unsigned c;
      int unsigned d1, d2;
      logic [27:0] img1;
      logic        seen_done;

      vecs[0]  = '{14'd1234,  {7'h79, 7'h24, 7'h30, 7'h19}};
      vecs[1]  = '{14'd7,     {7'h7F, 7'h7F, 7'h7F, 7'h78}};
      vecs[2]  = '{14'd0,     {7'h7F, 7'h7F, 7'h7F, 7'h40}};
      vecs[3]  = '{14'd16383, {7'h10, 7'h10, 7'h10, 7'h10}};
      vecs[4]  = '{14'd9999,  {7'h10, 7'h10, 7'h10, 7'h10}};
      vecs[5]  = '{14'd10000, {7'h10, 7'h10, 7'h10, 7'h10}};
      vecs[6]  = '{14'd10,    {7'h7F, 7'h7F, 7'h79, 7'h40}};
      vecs[7]  = '{14'd100,   {7'h7F, 7'h79, 7'h40, 7'h40}};
      vecs[8]  = '{14'd1000,  {7'h79, 7'h40, 7'h40, 7'h40}};
      vecs[9]  = '{14'd906,   {7'h7F, 7'h10, 7'h40, 7'h02}};
      vecs[10] = '{14'd5678,  {7'h12, 7'h02, 7'h78, 7'h00}};
      vecs[11] = '{14'd42,    {7'h7F, 7'h7F, 7'h19, 7'h24}};

      resetn   = 1'b0;
      in_valid = 1'b0;
      in_value = '0;
      #23;
      chk("rst hex", {4'd0, hex_out}, 32'h0FFFFFFF);
      chk("rst ctrl", {29'd0, in_ready, busy, done}, 3'b100);
      @(negedge clk);
      resetn = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("idle hex", {4'd0, hex_out}, 32'h0FFFFFFF);
      chk("idle ctrl", {29'd0, in_ready, busy, done}, 3'b100);

      for (int i = 0; i < 12; i++)
         run_value($sformatf("vec%0d", i), vecs[i].value, vecs[i].hex);

      // in_valid held high; value changes while busy and must not be taken early
      @(negedge clk);
      in_value  = 14'd5;
      in_valid  = 1'b1;
      @(posedge clk);
      #1;
      d1 = 0;
      d2 = 0;
      img1 = '0;
      for (c = 1; c <= 60; c++) begin
         @(posedge clk);
         #1;
         if (c == 3) in_value = 14'd42;
         if (done) begin
            if (d1 == 0) begin
               d1   = c;
               img1 = hex_out;
            end else begin
               d2 = c;
               break;
            end
         end
      end
      in_valid = 1'b0;
      chk("b2b first_done", d1, 19);
      chk("b2b first_hex", {4'd0, img1}, {4'd0, 7'h7F, 7'h7F, 7'h7F, 7'h12});
      chk("b2b second_done", d2, 39);
      chk("b2b final_hex", {4'd0, hex_out}, {4'd0, 7'h7F, 7'h7F, 7'h19, 7'h24});

      run_value("pre_rst", 14'd1234, {7'h79, 7'h24, 7'h30, 7'h19});

      // reset five edges into a conversion: image blanks at once, nothing commits
      @(negedge clk);
      in_value = 14'd5;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      resetn = 1'b0;
      #1;
      chk("midrst hex", {4'd0, hex_out}, 32'h0FFFFFFF);
      chk("midrst ctrl", {29'd0, in_ready, busy, done}, 3'b100);
      @(negedge clk);
      resetn = 1'b1;
      seen_done = 1'b0;
      repeat (25) begin
         @(posedge clk);
         #1;
         if (done) seen_done = 1'b1;
      end
      chk("midrst no_done", {31'd0, seen_done}, 0);
      chk("midrst hex_hold", {4'd0, hex_out}, 32'h0FFFFFFF);

      run_value("post_rst", 14'd88, {7'h7F, 7'h7F, 7'h00, 7'h00});

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
